jpeg_dht_sched: RTL and testbench

- Sequences Huffman table usage during entropy decode of each MCU.
- Selects which standard DHT lookup (Y DC, Y AC, Cx DC, Cx AC) the bitstream decoder must use for the next symbol.
- Tracks the coefficient position within each 8x8 block from accepted run/size symbols.
- Steps through the component blocks of each MCU according to the subsampling mode, and signals block, MCU and frame completion to the downstream dequant/IDCT path.

---
 rtl/jpeg_dht_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_jpeg_dht_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_dht_sched.sv
// JPEG entropy-decode scheduler: picks the DHT table for each symbol,
// tracks zigzag position and walks the blocks of every MCU in a frame.
module jpeg_dht_sched #(
  parameter int MCU_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic [MCU_CNT_W-1:0] mcu_count_i,
  input  logic                 sym_valid_i,
  input  logic [7:0]           sym_value_i,
  output logic                 sym_ready_o,
  output logic [1:0]           table_sel_o,
  output logic [1:0]           comp_o,
  output logic                 coeff_wr_o,
  output logic [5:0]           coeff_pos_o,
  output logic [3:0]           coeff_size_o,
  output logic                 block_done_o,
  output logic                 mcu_done_o,
  output logic                 frame_done_o,
  output logic                 busy_o,
  output logic                 error_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DC   = 2'd1,
    S_AC   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [MCU_CNT_W-1:0] mcu_max_q, mcu_max_d;
  logic [MCU_CNT_W-1:0] mcu_cnt_q, mcu_cnt_d;
  logic [MCU_CNT_W-1:0] mcu_nxt;
  logic [2:0]           blk_q, blk_d;
  logic [2:0]           blk_last;
  logic [6:0]           idx_q, idx_d;
  logic [6:0]           pos_w, zrl_w;
  logic                 err_q, err_d;
  logic                 coeff_wr_q, coeff_wr_d;
  logic [5:0]           coeff_pos_q, coeff_pos_d;
  logic [3:0]           coeff_size_q, coeff_size_d;
  logic                 block_done_q, block_done_d;
  logic                 mcu_done_q, mcu_done_d;
  logic                 ready, accept, blk_end;
  logic                 is_eob, is_zrl;
  logic [1:0]           comp;

  function automatic logic [2:0] last_blk(
    input logic [1:0] m
  );
    logic [2:0] l;
    l = 3'd0;
    unique case (m)
      2'd0: l = 3'd0;
      2'd1: l = 3'd2;
      2'd2: l = 3'd5;
      2'd3: l = 3'd3;
    endcase
    return l;
  endfunction

  // Chroma blocks always trail the luma blocks of an MCU.
  function automatic logic [1:0] blk_comp(
    input logic [1:0] m,
    input logic [2:0] b
  );
    logic [1:0] c;
    c = 2'd0;
    unique case (m)
      2'd0: c = 2'd0;
      2'd1: c = b[1:0];
      2'd2: c = (b == 3'd4) ? 2'd1 :
                (b == 3'd5) ? 2'd2 : 2'd0;
      2'd3: c = (b == 3'd2) ? 2'd1 :
                (b == 3'd3) ? 2'd2 : 2'd0;
    endcase
    return c;
  endfunction

  always_comb begin
    blk_last = last_blk(mode_q);
    comp     = blk_comp(mode_q, blk_q);
    ready    = (state_q == S_DC) || (state_q == S_AC);
    accept   = sym_valid_i && ready;
    is_eob   = (sym_value_i == 8'h00);
    is_zrl   = (sym_value_i == 8'hF0);
    pos_w    = idx_q + {3'b000, sym_value_i[7:4]};
    zrl_w    = idx_q + 7'd16;
    mcu_nxt  = mcu_cnt_q + MCU_CNT_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    mcu_max_d    = mcu_max_q;
    mcu_cnt_d    = mcu_cnt_q;
    blk_d        = blk_q;
    idx_d        = idx_q;
    err_d        = err_q;
    coeff_wr_d   = 1'b0;
    coeff_pos_d  = coeff_pos_q;
    coeff_size_d = coeff_size_q;
    block_done_d = 1'b0;
    mcu_done_d   = 1'b0;
    blk_end      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d    = mode_i;
          mcu_max_d = (mcu_count_i == '0) ?
                      MCU_CNT_W'(1) : mcu_count_i;
          mcu_cnt_d = '0;
          blk_d     = 3'd0;
          idx_d     = 7'd0;
          err_d     = 1'b0;
          state_d   = S_DC;
        end
      end
      S_DC: begin
        if (accept) begin
          coeff_wr_d   = 1'b1;
          coeff_pos_d  = 6'd0;
          coeff_size_d = sym_value_i[3:0];
          idx_d        = 7'd1;
          state_d      = S_AC;
        end
      end
      S_AC: begin
        if (accept) begin
          unique case (1'b1)
            is_eob: blk_end = 1'b1;
            is_zrl: begin
              idx_d = zrl_w;
              if (zrl_w >= 7'd64) blk_end = 1'b1;
              if (zrl_w > 7'd64) err_d = 1'b1;
            end
            default: begin
              if (pos_w > 7'd63) begin
                err_d   = 1'b1;
                blk_end = 1'b1;
              end else begin
                coeff_wr_d   = 1'b1;
                coeff_pos_d  = pos_w[5:0];
                coeff_size_d = sym_value_i[3:0];
                idx_d        = pos_w + 7'd1;
                if (pos_w == 7'd63) blk_end = 1'b1;
              end
            end
          endcase
        end
      end
      S_DONE: state_d = S_IDLE;
    endcase

    // Block advance happens on the terminating edge so the next DC
    // symbol can be taken in the same cycle block_done is seen.
    if (blk_end) begin
      block_done_d = 1'b1;
      idx_d        = 7'd0;
      if (blk_q == blk_last) begin
        mcu_done_d = 1'b1;
        blk_d      = 3'd0;
        mcu_cnt_d  = mcu_nxt;
        state_d    = (mcu_nxt == mcu_max_q) ? S_DONE : S_DC;
      end else begin
        blk_d   = blk_q + 3'd1;
        state_d = S_DC;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      mode_q       <= 2'd0;
      mcu_max_q    <= '0;
      mcu_cnt_q    <= '0;
      blk_q        <= 3'd0;
      idx_q        <= 7'd0;
      err_q        <= 1'b0;
      coeff_wr_q   <= 1'b0;
      coeff_pos_q  <= 6'd0;
      coeff_size_q <= 4'd0;
      block_done_q <= 1'b0;
      mcu_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      mcu_max_q    <= mcu_max_d;
      mcu_cnt_q    <= mcu_cnt_d;
      blk_q        <= blk_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      coeff_wr_q   <= coeff_wr_d;
      coeff_pos_q  <= coeff_pos_d;
      coeff_size_q <= coeff_size_d;
      block_done_q <= block_done_d;
      mcu_done_q   <= mcu_done_d;
    end
  end

  always_comb begin
    sym_ready_o  = ready;
    comp_o       = ready ? comp : 2'd0;
    table_sel_o  = 2'd0;
    if (ready) begin
      table_sel_o = {comp != 2'd0, state_q == S_AC};
    end
    coeff_wr_o   = coeff_wr_q;
    coeff_pos_o  = coeff_pos_q;
    coeff_size_o = coeff_size_q;
    block_done_o = block_done_q;
    mcu_done_o   = mcu_done_q;
    frame_done_o = (state_q == S_DONE);
    busy_o       = (state_q != S_IDLE);
    error_o      = err_q;
  end

endmodule

// File: tb/tb_jpeg_dht_sched.sv
// Scoreboard bench for jpeg_dht_sched: driver pushes expected events,
// a negedge monitor pops and compares them.
module tb_jpeg_dht_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  mode_i;
  logic [15:0] mcu_count_i;
  logic        sym_valid_i;
  logic [7:0]  sym_value_i;
  logic        sym_ready_o;
  logic [1:0]  table_sel_o;
  logic [1:0]  comp_o;
  logic        coeff_wr_o;
  logic [5:0]  coeff_pos_o;
  logic [3:0]  coeff_size_o;
  logic        block_done_o;
  logic        mcu_done_o;
  logic        frame_done_o;
  logic        busy_o;
  logic        error_o;

  jpeg_dht_sched #(.MCU_CNT_W(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .mcu_count_i  (mcu_count_i),
    .sym_valid_i  (sym_valid_i),
    .sym_value_i  (sym_value_i),
    .sym_ready_o  (sym_ready_o),
    .table_sel_o  (table_sel_o),
    .comp_o       (comp_o),
    .coeff_wr_o   (coeff_wr_o),
    .coeff_pos_o  (coeff_pos_o),
    .coeff_size_o (coeff_size_o),
    .block_done_o (block_done_o),
    .mcu_done_o   (mcu_done_o),
    .frame_done_o (frame_done_o),
    .busy_o       (busy_o),
    .error_o      (error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         bd;
    logic [5:0] pos;
    logic [3:0] size;
    bit         mcu;
    bit         frm;
  } ev_t;

  typedef struct {
    logic [1:0] tsel;
    logic [1:0] comp;
  } acc_t;

  ev_t  ev_q[$];
  acc_t acc_q[$];
  ev_t  mon_e;
  acc_t mon_a;
  int   total = 0;
  int   bad   = 0;
  bit   merr;
  logic [7:0] dir_dc;
  logic [7:0] dir_ac[$];

  // Component order of one MCU per mode, and block counts.
  int ord [4][6] = '{'{0,0,0,0,0,0}, '{0,1,2,0,0,0},
                     '{0,0,0,0,1,2}, '{0,0,1,2,0,0}};
  int nblk [4] = '{1, 3, 6, 4};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic push_acc(input int tsel, input int comp);
    acc_t a;
    a.tsel = 2'(tsel);
    a.comp = 2'(comp);
    acc_q.push_back(a);
  endtask

  task automatic push_wr(input int pos, input int size);
    ev_t e;
    e.bd = 1'b0; e.pos = 6'(pos); e.size = 4'(size);
    e.mcu = 1'b0; e.frm = 1'b0;
    ev_q.push_back(e);
  endtask

  task automatic push_bd(input bit lm, input bit lf);
    ev_t e;
    e.bd = 1'b1; e.pos = 6'd0; e.size = 4'd0;
    e.mcu = lm; e.frm = lf;
    ev_q.push_back(e);
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (sym_valid_i && sym_ready_o) begin
        if (acc_q.size() == 0) begin
          total++; bad++;
          $display("FAIL accept_unexpected got=%0h exp=none", sym_value_i);
        end else begin
          mon_a = acc_q.pop_front();
          chk("table_sel", 32'(table_sel_o), 32'(mon_a.tsel));
          chk("comp", 32'(comp_o), 32'(mon_a.comp));
        end
      end
      if (coeff_wr_o) begin
        if (ev_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected got=%0d exp=none", coeff_pos_o);
        end else begin
          mon_e = ev_q.pop_front();
          chk("wr_kind", 32'(mon_e.bd), 32'(0));
          chk("wr_pos", 32'(coeff_pos_o), 32'(mon_e.pos));
          chk("wr_size", 32'(coeff_size_o), 32'(mon_e.size));
        end
      end
      if (block_done_o) begin
        if (ev_q.size() == 0) begin
          total++; bad++;
          $display("FAIL bd_unexpected got=1 exp=0");
        end else begin
          mon_e = ev_q.pop_front();
          chk("bd_kind", 32'(mon_e.bd), 32'(1));
          chk("mcu_done", 32'(mcu_done_o), 32'(mon_e.mcu));
          chk("frame_done", 32'(frame_done_o), 32'(mon_e.frm));
        end
      end else if (mcu_done_o || frame_done_o) begin
        total++; bad++;
        $display("FAIL done_no_block got=%0b%0b exp=00",
                 mcu_done_o, frame_done_o);
      end
    end
  end

  task automatic send(input logic [7:0] v);
    int n;
    sym_valid_i = 1'b1;
    sym_value_i = v;
    n = 0;
    @(negedge clk_i);
    while (!sym_ready_o) begin
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL ready_timeout got=0 exp=1");
        finish_run();
      end
      @(negedge clk_i);
    end
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [7:0] rand_sym();
    int x;
    logic [3:0] r, s;
    x = $urandom_range(0, 99);
    if (x < 12) return 8'h00;
    if (x < 20) return 8'hF0;
    r = (x < 60) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    s = 4'($urandom_range(0, 10));
    return {r, s};
  endfunction

  task automatic set_dir(input int kind, input int b);
    dir_ac.delete();
    case (kind)
      1: begin dir_dc = 8'h03; dir_ac = '{8'h02, 8'h00}; end
      2: begin dir_dc = 8'h00; dir_ac = '{8'h00}; end
      3: begin dir_dc = 8'h00; dir_ac = '{8'hF0, 8'hF0, 8'hF0, 8'hE1}; end
      4: begin
        if (b == 0) begin
          dir_dc = 8'h05;
          dir_ac = '{8'hF0, 8'hF0, 8'hF0, 8'hA1, 8'h51};
        end else begin
          dir_dc = 8'h01; dir_ac = '{8'h00};
        end
      end
      default: dir_dc = 8'h00;
    endcase
  endtask

  // Reference: k is the next zigzag slot to fill in the block.
  task automatic run_block(input int kind, input int comp,
                           input bit lm, input bit lf);
    logic [7:0] s, dc;
    int k, p;
    bit ended;
    dc = (kind == 0) ? 8'($urandom_range(0, 11)) : dir_dc;
    if (kind == 0) begin
      start_i = 1'($urandom_range(0, 1));
      mode_i  = 2'($urandom_range(0, 3));
    end
    push_acc(comp != 0 ? 2 : 0, comp);
    push_wr(0, int'(dc[3:0]));
    send(dc);
    k = 1;
    ended = 1'b0;
    while (!ended) begin
      if (kind == 0) s = rand_sym();
      else s = (dir_ac.size() > 0) ? dir_ac.pop_front() : 8'h00;
      push_acc(comp != 0 ? 3 : 1, comp);
      if (s == 8'h00) begin
        ended = 1'b1;
      end else if (s == 8'hF0) begin
        k += 16;
        if (k >= 64) ended = 1'b1;
        if (k > 64) merr = 1'b1;
      end else begin
        p = k + int'(s[7:4]);
        if (p > 63) begin
          merr = 1'b1;
          ended = 1'b1;
        end else begin
          push_wr(p, int'(s[3:0]));
          k = p + 1;
          if (p == 63) ended = 1'b1;
        end
      end
      if (ended) push_bd(lm, lf);
      send(s);
    end
    start_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(sym_ready_o), 0);
    chk({tag, "_tsel"}, 32'(table_sel_o), 0);
    chk({tag, "_comp"}, 32'(comp_o), 0);
    chk({tag, "_wr"}, 32'(coeff_wr_o), 0);
    chk({tag, "_pos"}, 32'(coeff_pos_o), 0);
    chk({tag, "_size"}, 32'(coeff_size_o), 0);
    chk({tag, "_bd"}, 32'(block_done_o), 0);
    chk({tag, "_md"}, 32'(mcu_done_o), 0);
    chk({tag, "_fd"}, 32'(frame_done_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_err"}, 32'(error_o), 0);
  endtask

  task automatic run_frame(input int mode, input int mcnt,
                           input int kind, input bit abort);
    int nm, nb;
    logic [7:0] dc;
    @(negedge clk_i);
    start_i = 1'b1;
    mode_i = 2'(mode);
    mcu_count_i = 16'(mcnt);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    chk("start_busy", 32'(busy_o), 1);
    chk("start_err", 32'(error_o), 0);
    chk("start_ready", 32'(sym_ready_o), 1);
    merr = 1'b0;
    nm = (mcnt == 0) ? 1 : mcnt;
    nb = nblk[mode];
    for (int m = 0; m < nm; m++) begin
      for (int b = 0; b < nb; b++) begin
        if (abort && m == 0 && b == 3) begin
          dc = 8'($urandom_range(0, 11));
          push_acc(ord[mode][b] != 0 ? 2 : 0, ord[mode][b]);
          push_wr(0, int'(dc[3:0]));
          send(dc);
          push_acc(ord[mode][b] != 0 ? 3 : 1, ord[mode][b]);
          push_wr(2, 1);
          send(8'h11);
          sym_valid_i = 1'b0;
          @(negedge clk_i);
          #1;
          rst_i = 1'b1;
          @(posedge clk_i);
          #1;
          chk_zero("abort");
          chk("abort_evq", 32'(ev_q.size()), 0);
          chk("abort_accq", 32'(acc_q.size()), 0);
          ev_q.delete();
          acc_q.delete();
          @(negedge clk_i);
          rst_i = 1'b0;
          return;
        end
        set_dir(kind, b);
        run_block(kind, ord[mode][b], b == nb - 1,
                  (b == nb - 1) && (m == nm - 1));
      end
    end
    // Valid stays asserted through DONE and IDLE.
    chk("done_fd", 32'(frame_done_o), 1);
    chk("done_ready", 32'(sym_ready_o), 0);
    chk("done_busy", 32'(busy_o), 1);
    chk("done_err", 32'(error_o), 32'(merr));
    @(posedge clk_i);
    #1;
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_ready", 32'(sym_ready_o), 0);
    chk("idle_fd", 32'(frame_done_o), 0);
    @(posedge clk_i);
    #1;
    chk("idle2_ready", 32'(sym_ready_o), 0);
    sym_valid_i = 1'b0;
    chk("frame_evq", 32'(ev_q.size()), 0);
    chk("frame_accq", 32'(acc_q.size()), 0);
  endtask

  initial begin
    #5_000_000;
    total++; bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    finish_run();
  end

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    mode_i = 2'd0;
    mcu_count_i = 16'd0;
    sym_valid_i = 1'b0;
    sym_value_i = 8'h00;
    repeat (2) @(posedge clk_i);
    #1;
    chk_zero("reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    run_frame(0, 1, 1, 1'b0);
    run_frame(2, 2, 2, 1'b0);
    run_frame(0, 1, 3, 1'b0);
    run_frame(1, 1, 4, 1'b0);
    run_frame(1, 2, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      run_frame($urandom_range(0, 3), $urandom_range(0, 3), 0, 1'b0);
    end
    run_frame(2, 1, 0, 1'b1);
    run_frame(2, 1, 0, 1'b0);
    finish_run();
  end

endmodule
